// File: rtl/fetch_stage.sv
// fetch_stage: PC owner and IF/ID register with stall, redirect/flush, misaligned trap and ECALL halt
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013,
  parameter bit HALT_ON_ECALL = 1'b1,
  parameter int COUNT_W = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic stall,
  input  logic redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_address,
  output logic [31:0] imem_data_in,
  output logic imem_read_write,
  input  logic [31:0] imem_data_out,
  output logic [31:0] if_pc,
  output logic [31:0] if_insn,
  output logic if_valid,
  output logic halted,
  output logic misaligned,
  output logic [COUNT_W-1:0] fetch_count
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t state, state_n;
  logic [31:0] pc, pc_n, if_pc_n, if_insn_n;
  logic if_valid_n, misaligned_n, aligned, ecall;
  logic [COUNT_W-1:0] count_n;
  assign imem_address = pc;
  assign imem_data_in = 32'h0;
  assign imem_read_write = 1'b0;
  assign halted = state == HALT;
  assign aligned = redirect_pc[1:0] == 2'b00;
  assign ecall = HALT_ON_ECALL && imem_data_out == 32'h0000_0073;
  always_comb begin
    state_n = state;
    pc_n = pc;
    if_pc_n = if_pc;
    if_insn_n = if_insn;
    if_valid_n = if_valid;
    misaligned_n = misaligned;
    count_n = fetch_count;
    if (state == BOOT) state_n = RUN;
    else if (state == RUN) begin
      if (redirect_valid && aligned) begin
        pc_n = redirect_pc;
        if_valid_n = 1'b0;
        if_insn_n = NOP_INSN;
      end else if (redirect_valid) begin
        misaligned_n = 1'b1;
        if_valid_n = 1'b0;
        state_n = HALT;
      end else if (!stall) begin
        if_insn_n = imem_data_out;
        if_pc_n = pc;
        if_valid_n = 1'b1;
        count_n = fetch_count + COUNT_W'(1);
        pc_n = ecall ? pc : pc + 32'd4;
        state_n = ecall ? HALT : RUN;
      end
    end else begin
      // a halt caused by a bad target is only left through reset
      if (redirect_valid && aligned && !misaligned) begin
        pc_n = redirect_pc;
        if_valid_n = 1'b0;
        if_insn_n = NOP_INSN;
        state_n = RUN;
      end else if (!stall) begin
        if_valid_n = 1'b0;
        if_insn_n = NOP_INSN;
      end
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= BOOT;
      pc <= RESET_PC;
      if_pc <= RESET_PC;
      if_insn <= NOP_INSN;
      if_valid <= 1'b0;
      misaligned <= 1'b0;
      fetch_count <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      if_pc <= if_pc_n;
      if_insn <= if_insn_n;
      if_valid <= if_valid_n;
      misaligned <= misaligned_n;
      fetch_count <= count_n;
    end
  end
endmodule
